gate_list_execute_sm: RTL

- Implements the 802.1Q-2018 8.6.9.2 List Execute state machine for the TSN switch egress.
- Sits directly downstream of the cycle timer. It consumes the one-clock CycleStart pulse and walks the gate control list (GCL).
- Drives per-queue transmission gate states to the egress transmission selection logic.
- The GCL lives in an internal register array, loaded through a simple write port from the control-register block.

---
 rtl/gate_list_execute_sm_if.sv | 32 +++
 rtl/gate_list_execute_sm.sv | 108 ++++++++++
 2 files changed

// File: rtl/gate_list_execute_sm_if.sv
// Control/status bundle between the cycle timer / config block and the
// 802.1Q List Execute state machine.
interface gate_list_execute_sm_if #(
  parameter int NUM_QUEUES = 8,
  parameter int ADDR_W     = 4,
  parameter int INTERVAL_W = 32
);
  logic                  cycle_start;
  logic                  gate_enable;
  logic [NUM_QUEUES-1:0] admin_gate_states;
  logic [ADDR_W:0]       cfg_list_len;
  logic                  cfg_wr_en;
  logic [ADDR_W-1:0]     cfg_wr_addr;
  logic [NUM_QUEUES-1:0] cfg_wr_gates;
  logic [INTERVAL_W-1:0] cfg_wr_interval;
  logic [NUM_QUEUES-1:0] oper_gate_states;
  logic                  list_active;
  logic [ADDR_W-1:0]     list_index;
  logic                  cycle_overrun;

  modport master (
    output cycle_start, gate_enable, admin_gate_states, cfg_list_len,
           cfg_wr_en, cfg_wr_addr, cfg_wr_gates, cfg_wr_interval,
    input  oper_gate_states, list_active, list_index, cycle_overrun
  );

  modport slave (
    input  cycle_start, gate_enable, admin_gate_states, cfg_list_len,
           cfg_wr_en, cfg_wr_addr, cfg_wr_gates, cfg_wr_interval,
    output oper_gate_states, list_active, list_index, cycle_overrun
  );
endinterface

// File: rtl/gate_list_execute_sm.sv
// 802.1Q List Execute state machine: walks the gate control list on each
// CycleStart and drives the per-queue transmission gate states.
module gate_list_execute_sm #(
  parameter int NUM_QUEUES    = 8,
  parameter int LIST_DEPTH    = 16,
  parameter int ADDR_W        = 4,
  parameter int INTERVAL_W    = 32,
  parameter int CLK_PERIOD_NS = 8
) (
  input logic               clk,
  input logic               rst,
  gate_list_execute_sm_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXECUTE, END_OF_CYCLE} state_t;

  localparam logic [INTERVAL_W-1:0] PERIOD = INTERVAL_W'(CLK_PERIOD_NS);
  localparam logic [ADDR_W:0]       DEPTH  = (ADDR_W+1)'(LIST_DEPTH);

  logic [NUM_QUEUES-1:0] r_gcl_gates [LIST_DEPTH];
  logic [INTERVAL_W-1:0] r_gcl_intv  [LIST_DEPTH];

  state_t                r_state;
  logic [NUM_QUEUES-1:0] r_oper_gates;
  logic                  r_list_active;
  logic                  r_overrun;
  logic [ADDR_W-1:0]     r_list_index;
  logic [ADDR_W:0]       r_oper_len;
  logic [ADDR_W:0]       r_next_idx;
  logic [INTERVAL_W-1:0] r_remaining;

  logic                  w_wr_ok;
  logic [ADDR_W-1:0]     w_next_addr;

  assign w_wr_ok     = bus.cfg_wr_en && ({1'b0, bus.cfg_wr_addr} < DEPTH);
  assign w_next_addr = r_next_idx[ADDR_W-1:0];

  // List storage is deliberately not reset; entries are copied into the
  // operating registers on load, so later writes never disturb a running hold.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_gcl_gates[bus.cfg_wr_addr] <= bus.cfg_wr_gates;
      r_gcl_intv[bus.cfg_wr_addr]  <= bus.cfg_wr_interval;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_oper_gates  <= '1;
      r_list_active <= 1'b0;
      r_overrun     <= 1'b0;
      r_list_index  <= '0;
      r_oper_len    <= '0;
      r_next_idx    <= '0;
      r_remaining   <= '0;
    end else begin
      r_overrun <= 1'b0;
      if (!bus.gate_enable) begin
        r_state       <= IDLE;
        r_oper_gates  <= bus.admin_gate_states;
        r_list_active <= 1'b0;
      end else if (bus.cycle_start) begin
        r_overrun <= (r_state == EXECUTE);
        if (bus.cfg_list_len == '0) begin
          r_state       <= END_OF_CYCLE;
          r_oper_gates  <= bus.admin_gate_states;
          r_list_active <= 1'b0;
        end else begin
          r_state       <= EXECUTE;
          r_list_active <= 1'b1;
          r_oper_len    <= bus.cfg_list_len;
          r_oper_gates  <= r_gcl_gates[0];
          r_remaining   <= r_gcl_intv[0];
          r_list_index  <= '0;
          r_next_idx    <= (ADDR_W+1)'(1);
        end
      end else begin
        case (r_state)
          EXECUTE: begin
            // Advance on the edge where the remainder fits in one period, so
            // an entry holds max(1, ceil(interval/period)) cycles with no gap.
            if (r_remaining <= PERIOD) begin
              if (r_next_idx == r_oper_len) begin
                r_state       <= END_OF_CYCLE;
                r_list_active <= 1'b0;
              end else begin
                r_oper_gates <= r_gcl_gates[w_next_addr];
                r_remaining  <= r_gcl_intv[w_next_addr];
                r_list_index <= w_next_addr;
                r_next_idx   <= r_next_idx + 1'b1;
              end
            end else begin
              r_remaining <= r_remaining - PERIOD;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.oper_gate_states = r_oper_gates;
  assign bus.list_active      = r_list_active;
  assign bus.list_index       = r_list_index;
  assign bus.cycle_overrun    = r_overrun;

endmodule
